vscale_alu_arbiter: RTL and testbench

Shares the single EX-stage ALU, and its `src_b` operand mux, between the main pipeline and one auxiliary requester (debug/AMO/address helper). The pipeline has priority. The auxiliary port gets the ALU when the pipeline does not need it, or after a bounded wait, at which point the arbiter stalls the pipeline for one cycle. The block drives `src_b_sel`, `alu_op` and an operand-source override for the datapath. It also registers the ALU result back to the auxiliary requester with a valid/ready response.

---
 rtl/vscale_alu_arbiter_if.sv | 35 +++
 rtl/vscale_alu_arbiter.sv | 81 ++++++++
 tb/tb_vscale_alu_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vscale_alu_arbiter_if.sv
// Auxiliary requester port of the EX-stage ALU arbiter: request (operand select + op)
// and registered response handshake. The master modport is the requester side.
interface vscale_alu_arbiter_if #(
    parameter int XPR_LEN         = 32,
    parameter int SRC_B_SEL_WIDTH = 2,
    parameter int ALU_OP_WIDTH    = 4
);
    logic                       aux_req_valid;
    logic                       aux_req_ready;
    logic [SRC_B_SEL_WIDTH-1:0] aux_src_b_sel;
    logic [ALU_OP_WIDTH-1:0]    aux_alu_op;
    logic                       aux_resp_valid;
    logic                       aux_resp_ready;
    logic [XPR_LEN-1:0]         aux_resp_data;

    modport master (
        output aux_req_valid,
        output aux_src_b_sel,
        output aux_alu_op,
        output aux_resp_ready,
        input  aux_req_ready,
        input  aux_resp_valid,
        input  aux_resp_data
    );

    modport slave (
        input  aux_req_valid,
        input  aux_src_b_sel,
        input  aux_alu_op,
        input  aux_resp_ready,
        output aux_req_ready,
        output aux_resp_valid,
        output aux_resp_data
    );
endinterface

// File: rtl/vscale_alu_arbiter.sv
// Shares the EX-stage ALU between the pipeline (priority) and one aux requester,
// forcing a one-cycle pipeline stall once the aux request has waited MAX_WAIT cycles.
module vscale_alu_arbiter #(
    parameter int XPR_LEN         = 32,
    parameter int MAX_WAIT        = 4,
    parameter int SRC_B_SEL_WIDTH = 2,
    parameter int ALU_OP_WIDTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pipe_valid,
    input  logic                       pipe_stall_in,
    input  logic [SRC_B_SEL_WIDTH-1:0] pipe_src_b_sel,
    input  logic [ALU_OP_WIDTH-1:0]    pipe_alu_op,
    output logic                       pipe_stall,
    vscale_alu_arbiter_if.slave        aux,
    output logic                       aux_sel,
    output logic [SRC_B_SEL_WIDTH-1:0] src_b_sel,
    output logic [ALU_OP_WIDTH-1:0]    alu_op,
    input  logic [XPR_LEN-1:0]         alu_out
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic               resp_pending_q, resp_pending_d;
    logic [XPR_LEN-1:0] resp_data_q,    resp_data_d;
    logic [CNT_W-1:0]   wait_cnt_q,     wait_cnt_d;

    logic starve;
    logic pipe_busy;
    logic slot_free;
    logic grant;

    always_comb begin
        starve    = (wait_cnt_q >= CNT_MAX);
        pipe_busy = pipe_valid && !pipe_stall_in;
        // A new grant may overlap the cycle in which the previous response retires.
        slot_free = !resp_pending_q || aux.aux_resp_ready;
        grant     = reset_n && aux.aux_req_valid && slot_free && (!pipe_busy || starve);

        aux.aux_req_ready = grant;
        pipe_stall        = grant && pipe_busy;
        aux_sel           = grant;
        src_b_sel         = grant ? aux.aux_src_b_sel : pipe_src_b_sel;
        alu_op            = grant ? aux.aux_alu_op    : pipe_alu_op;
    end

    always_comb begin
        wait_cnt_d     = wait_cnt_q;
        resp_pending_d = resp_pending_q;
        resp_data_d    = resp_data_q;

        if (grant || !aux.aux_req_valid) begin
            wait_cnt_d = '0;
        end else if (!starve) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (grant) begin
            resp_pending_d = 1'b1;
            resp_data_d    = alu_out;
        end else if (aux.aux_resp_ready) begin
            resp_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_pending_q <= 1'b0;
            resp_data_q    <= '0;
            wait_cnt_q     <= '0;
        end else begin
            resp_pending_q <= resp_pending_d;
            resp_data_q    <= resp_data_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign aux.aux_resp_valid = resp_pending_q;
    assign aux.aux_resp_data  = resp_data_q;
endmodule

// File: tb/tb_vscale_alu_arbiter.sv
// Directed-vector bench for vscale_alu_arbiter: per-cycle grant/stall/mux checks plus a
// scoreboard queue of expected aux responses drained by an independent monitor.
module tb_vscale_alu_arbiter;
    localparam int XW = 32;
    localparam int SW = 2;
    localparam int OW = 4;
    localparam logic [SW-1:0] PIPE_SEL = 2'd1;
    localparam logic [OW-1:0] PIPE_OP  = 4'd5;
    localparam logic [SW-1:0] AUX_SEL  = 2'd3;
    localparam logic [OW-1:0] AUX_OP   = 4'd0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pipe_valid = 1'b0;
    logic          pipe_stall_in = 1'b0;
    logic [SW-1:0] pipe_src_b_sel = PIPE_SEL;
    logic [OW-1:0] pipe_alu_op = PIPE_OP;
    logic          pipe_stall;
    logic          aux_sel;
    logic [SW-1:0] src_b_sel;
    logic [OW-1:0] alu_op;
    logic [XW-1:0] alu_out = '0;

    int errors = 0;
    int checks = 0;
    logic [XW-1:0] exp_q[$];

    vscale_alu_arbiter_if #(.XPR_LEN(XW), .SRC_B_SEL_WIDTH(SW), .ALU_OP_WIDTH(OW)) aux ();

    vscale_alu_arbiter #(.XPR_LEN(XW), .MAX_WAIT(4), .SRC_B_SEL_WIDTH(SW), .ALU_OP_WIDTH(OW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pipe_valid     (pipe_valid),
        .pipe_stall_in  (pipe_stall_in),
        .pipe_src_b_sel (pipe_src_b_sel),
        .pipe_alu_op    (pipe_alu_op),
        .pipe_stall     (pipe_stall),
        .aux            (aux.slave),
        .aux_sel        (aux_sel),
        .src_b_sel      (src_b_sel),
        .alu_op         (alu_op),
        .alu_out        (alu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One directed cycle: drive after the edge, check mid-cycle, record expected response.
    task automatic cyc(input string name, input logic pv, input logic psi, input logic av,
                       input logic rr, input logic [XW-1:0] aout,
                       input logic eg, input logic es, input logic erv);
        @(posedge clk);
        #1;
        pipe_valid         = pv;
        pipe_stall_in      = psi;
        aux.aux_req_valid  = av;
        aux.aux_resp_ready = rr;
        alu_out            = aout;
        @(negedge clk);
        chk({name, ".grant"},     XW'(aux.aux_req_ready),  XW'(eg));
        chk({name, ".stall"},     XW'(pipe_stall),         XW'(es));
        chk({name, ".aux_sel"},   XW'(aux_sel),            XW'(eg));
        chk({name, ".rvalid"},    XW'(aux.aux_resp_valid), XW'(erv));
        chk({name, ".src_b_sel"}, XW'(src_b_sel),          XW'(eg ? AUX_SEL : PIPE_SEL));
        chk({name, ".alu_op"},    XW'(alu_op),             XW'(eg ? AUX_OP : PIPE_OP));
        $display("cycle %s: pv=%0b psi=%0b av=%0b rr=%0b grant=%0b stall=%0b rvalid=%0b rdata=0x%0h",
                 name, pv, psi, av, rr, aux.aux_req_ready, pipe_stall, aux.aux_resp_valid,
                 aux.aux_resp_data);
        if (eg) exp_q.push_back(aout);
    endtask

    // Monitor: every consumed response must match the oldest expected value.
    always @(negedge clk) begin
        #1;
        if (aux.aux_resp_valid && aux.aux_resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got 0x%0h expected no response", aux.aux_resp_data);
            end else begin
                logic [XW-1:0] e;
                e = exp_q.pop_front();
                if (aux.aux_resp_data !== e) begin
                    errors++;
                    $display("FAIL resp_data: got 0x%0h expected 0x%0h", aux.aux_resp_data, e);
                end
            end
        end
    end

    initial begin
        aux.aux_req_valid  = 1'b1;
        aux.aux_resp_ready = 1'b1;
        aux.aux_src_b_sel  = AUX_SEL;
        aux.aux_alu_op     = AUX_OP;
        pipe_valid         = 1'b1;
        #3;
        chk("reset.grant",     XW'(aux.aux_req_ready),  0);
        chk("reset.stall",     XW'(pipe_stall),         0);
        chk("reset.aux_sel",   XW'(aux_sel),            0);
        chk("reset.rvalid",    XW'(aux.aux_resp_valid), 0);
        chk("reset.src_b_sel", XW'(src_b_sel),          XW'(PIPE_SEL));
        chk("reset.alu_op",    XW'(alu_op),             XW'(PIPE_OP));
        aux.aux_req_valid = 1'b0;
        pipe_valid        = 1'b0;
        #9 reset_n = 1'b1;

        // Idle pipe: immediate grant, response next cycle.
        cyc("idle0", 0, 0, 1, 1, 32'h15, 1, 0, 0);
        cyc("idle1", 0, 0, 0, 1, 32'h0,  0, 0, 1);

        // Starvation: four refusals, then one forced-stall grant.
        for (int i = 0; i < 4; i++) cyc($sformatf("starve%0d", i), 1, 0, 1, 1, 32'hA0 + i, 0, 0, 0);
        cyc("starve4", 1, 0, 1, 1, 32'hA4, 1, 1, 0);
        cyc("starve5", 1, 0, 1, 1, 32'hA5, 0, 0, 1);
        cyc("starve6", 1, 0, 0, 1, 32'h0,  0, 0, 0);

        // External stall lets aux in without a forced stall.
        cyc("xstall0", 1, 1, 1, 1, 32'h33, 1, 0, 0);
        cyc("xstall1", 0, 0, 0, 1, 32'h0,  0, 0, 1);

        // Response backpressure, then overlapped retire + new grant.
        cyc("bp0", 0, 0, 1, 0, 32'h41, 1, 0, 0);
        cyc("bp1", 0, 0, 1, 0, 32'h42, 0, 0, 1);
        cyc("bp2", 0, 0, 1, 0, 32'h43, 0, 0, 1);
        chk("bp2.hold_data", aux.aux_resp_data, 32'h41);
        cyc("bp3", 0, 0, 1, 1, 32'h44, 1, 0, 1);
        cyc("bp4", 0, 0, 0, 1, 32'h0,  0, 0, 1);

        // Streaming at one op per cycle.
        for (int i = 0; i < 8; i++)
            cyc($sformatf("stream%0d", i), 0, 0, 1, 1, 32'h50 + i, 1, 0, (i > 0));
        cyc("stream8", 0, 0, 0, 1, 32'h0, 0, 0, 1);

        // Asynchronous reset while a response is pending.
        cyc("arst0", 0, 0, 1, 0, 32'h77, 1, 0, 0);
        @(posedge clk);
        #3;
        reset_n           = 1'b0;
        aux.aux_req_valid = 1'b0;
        #1;
        chk("arst.rvalid",   XW'(aux.aux_resp_valid), 0);
        chk("arst.grant",    XW'(aux.aux_req_ready),  0);
        chk("arst.wait_cnt", XW'(dut.wait_cnt_q),     0);
        $display("cycle arst: reset pulse, rvalid=%0b grant=%0b", aux.aux_resp_valid, aux.aux_req_ready);
        exp_q.delete();
        #1 reset_n = 1'b1;

        for (int i = 0; i < 4; i++) cyc($sformatf("rstarve%0d", i), 1, 0, 1, 1, 32'hC0 + i, 0, 0, 0);
        cyc("rstarve4", 1, 0, 1, 1, 32'hC4, 1, 1, 0);
        cyc("rstarve5", 0, 0, 0, 1, 32'h0,  0, 0, 1);
        cyc("drain",    0, 0, 0, 1, 32'h0,  0, 0, 0);

        chk("scoreboard_empty", XW'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
